// File: rtl/box_raster_engine.sv
// ============================================================================
// box_raster_engine
// ----------------------------------------------------------------------------
// Purpose:
//   VGA box plotter. Captures an X coordinate, then Y, colour and a runtime
//   box size, and streams one pixel per cycle to the vga_adapter plot port.
//   Pixels that fall off the screen edge are clipped (their cycle is still
//   spent). A full-screen clear writes CLEAR_COLOUR to every pixel.
//
// Optional feature macro:
//   BOX_OUTLINE_EN - adds iOutline; when latched high only the box perimeter
//                    is plotted (interior cycles still elapse with oPlot=0).
//
// Ports:
//   iClock     in   1       system clock
//   iResetn    in   1       synchronous active-low reset
//   iLoadX     in   1       level, held high to capture X from iXY_Coord
//   iPlotBox   in   1       level, held high to capture Y/colour/size;
//                           falling edge starts the draw
//   iBlack     in   1       starts a full-screen clear (ignored mid-clear)
//   iXY_Coord  in   X_W     coordinate bus, Y uses the low Y_W bits
//   iColour    in   3       box colour
//   iBoxW      in   SIZE_W  box width in pixels, 0 behaves as 1
//   iBoxH      in   SIZE_W  box height in pixels, 0 behaves as 1
//   iOutline   in   1       (BOX_OUTLINE_EN only) draw perimeter only
//   oX/oY      out          pixel address, valid when oPlot=1
//   oColour    out  3       pixel colour, valid when oPlot=1
//   oPlot      out  1       pixel write enable
//   oBusy      out  1       high while drawing or clearing
//   oDone      out  1       high in DONE until the next capture or clear
//
// The draw/clear column and row counters are X_W and Y_W bits wide and are
// shared by both operations, so SIZE_W must not exceed Y_W.
// ============================================================================
module box_raster_engine #(
    parameter int         X_SCREEN_PIXELS = 160,
    parameter int         Y_SCREEN_PIXELS = 120,
    parameter int         SIZE_W          = 4,
    parameter logic [2:0] CLEAR_COLOUR    = 3'b000,
    localparam int        X_W             = $clog2(X_SCREEN_PIXELS),
    localparam int        Y_W             = $clog2(Y_SCREEN_PIXELS)
) (
    input  logic              iClock,
    input  logic              iResetn,
    input  logic              iLoadX,
    input  logic              iPlotBox,
    input  logic              iBlack,
    input  logic [X_W-1:0]    iXY_Coord,
    input  logic [2:0]        iColour,
    input  logic [SIZE_W-1:0] iBoxW,
    input  logic [SIZE_W-1:0] iBoxH,
`ifdef BOX_OUTLINE_EN
    input  logic              iOutline,
`endif
    output logic [X_W-1:0]    oX,
    output logic [Y_W-1:0]    oY,
    output logic [2:0]        oColour,
    output logic              oPlot,
    output logic              oBusy,
    output logic              oDone
);

    typedef enum logic [2:0] {
        S_LOAD_X,
        S_LOAD_Y,
        S_DRAW,
        S_CLEAR,
        S_DONE
    } state_t;

    localparam logic [X_W:0]   X_LIMIT = (X_W+1)'(X_SCREEN_PIXELS);
    localparam logic [Y_W:0]   Y_LIMIT = (Y_W+1)'(Y_SCREEN_PIXELS);
    localparam logic [X_W-1:0] X_LAST  = X_W'(X_SCREEN_PIXELS - 1);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(Y_SCREEN_PIXELS - 1);

    state_t            state_q;
    logic              seen_q;
    logic              lastDone_q;
    logic [X_W-1:0]    xBase_q;
    logic [Y_W-1:0]    yBase_q;
    logic [2:0]        boxColour_q;
    logic [X_W-1:0]    wLast_q;
    logic [Y_W-1:0]    hLast_q;
    logic [X_W-1:0]    colCnt_q;
    logic [Y_W-1:0]    rowCnt_q;
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic [2:0]        colour_q;
    logic              plot_q;
    logic              busy_q;
    logic              done_q;
`ifdef BOX_OUTLINE_EN
    logic              outline_q;
`endif

    logic [X_W:0]      drawX_d;
    logic [Y_W:0]      drawY_d;
    logic              inScreen_d;
    logic [X_W-1:0]    colEnd_d;
    logic [Y_W-1:0]    rowEnd_d;
    logic              colLast_d;
    logic              rowLast_d;
    logic              perimeter_d;
    logic [SIZE_W-1:0] wLatch_d;
    logic [SIZE_W-1:0] hLatch_d;

    // Address arithmetic is one bit wider than the screen so boxes that run
    // past the edge are detected instead of wrapping onto the far side.
    // The counters' end points depend on whether a box or the whole screen
    // is being swept. Box sizes are stored as "last index" so 0 and 1 both
    // give a single pixel.
    always_comb begin
        drawX_d     = {1'b0, xBase_q} + {1'b0, colCnt_q};
        drawY_d     = {1'b0, yBase_q} + {1'b0, rowCnt_q};
        inScreen_d  = (drawX_d < X_LIMIT) && (drawY_d < Y_LIMIT);
        colEnd_d    = (state_q == S_CLEAR) ? X_LAST : wLast_q;
        rowEnd_d    = (state_q == S_CLEAR) ? Y_LAST : hLast_q;
        colLast_d   = (colCnt_q == colEnd_d);
        rowLast_d   = (rowCnt_q == rowEnd_d);
        perimeter_d = 1'b1;
`ifdef BOX_OUTLINE_EN
        perimeter_d = !outline_q || (colCnt_q == '0) || colLast_d ||
                      (rowCnt_q == '0) || rowLast_d;
`endif
        wLatch_d    = (iBoxW == '0) ? '0 : iBoxW - SIZE_W'(1);
        hLatch_d    = (iBoxH == '0) ? '0 : iBoxH - SIZE_W'(1);
    end

    // Single control FSM with registered outputs. iBlack is checked ahead of
    // the per-state logic so it beats any capture or draw in progress.
    // DRAW and CLEAR share one sweep: each cycle registers the current
    // counter position, and once the final position has been emitted
    // lastDone_q makes the following cycle move to DONE.
    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            state_q     <= S_LOAD_X;
            seen_q      <= 1'b0;
            lastDone_q  <= 1'b0;
            xBase_q     <= '0;
            yBase_q     <= '0;
            boxColour_q <= '0;
            wLast_q     <= '0;
            hLast_q     <= '0;
            colCnt_q    <= '0;
            rowCnt_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            colour_q    <= '0;
            plot_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef BOX_OUTLINE_EN
            outline_q   <= 1'b0;
`endif
        end else begin
            plot_q <= 1'b0;
            if (iBlack && (state_q != S_CLEAR)) begin
                state_q    <= S_CLEAR;
                seen_q     <= 1'b0;
                lastDone_q <= 1'b0;
                colCnt_q   <= '0;
                rowCnt_q   <= '0;
                busy_q     <= 1'b1;
                done_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_LOAD_X: begin
                        if (iLoadX) begin
                            xBase_q <= iXY_Coord;
                            seen_q  <= 1'b1;
                        end else if (seen_q) begin
                            seen_q  <= 1'b0;
                            state_q <= S_LOAD_Y;
                        end
                    end
                    S_LOAD_Y: begin
                        if (iPlotBox) begin
                            yBase_q     <= iXY_Coord[Y_W-1:0];
                            boxColour_q <= iColour;
                            wLast_q     <= X_W'(wLatch_d);
                            hLast_q     <= Y_W'(hLatch_d);
`ifdef BOX_OUTLINE_EN
                            outline_q   <= iOutline;
`endif
                            seen_q      <= 1'b1;
                        end else if (seen_q) begin
                            seen_q     <= 1'b0;
                            lastDone_q <= 1'b0;
                            colCnt_q   <= '0;
                            rowCnt_q   <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= S_DRAW;
                        end
                    end
                    S_DRAW, S_CLEAR: begin
                        if (lastDone_q) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            if (state_q == S_CLEAR) begin
                                x_q      <= colCnt_q;
                                y_q      <= rowCnt_q;
                                colour_q <= CLEAR_COLOUR;
                                plot_q   <= 1'b1;
                            end else begin
                                x_q      <= drawX_d[X_W-1:0];
                                y_q      <= drawY_d[Y_W-1:0];
                                colour_q <= boxColour_q;
                                plot_q   <= inScreen_d && perimeter_d;
                            end
                            if (colLast_d) begin
                                colCnt_q <= '0;
                                if (rowLast_d) begin
                                    lastDone_q <= 1'b1;
                                end else begin
                                    rowCnt_q <= rowCnt_q + Y_W'(1);
                                end
                            end else begin
                                colCnt_q <= colCnt_q + X_W'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        if (iLoadX) begin
                            xBase_q <= iXY_Coord;
                            seen_q  <= 1'b1;
                            done_q  <= 1'b0;
                            state_q <= S_LOAD_X;
                        end
                    end
                    default: begin
                        state_q <= S_LOAD_X;
                    end
                endcase
            end
        end
    end

    assign oX      = x_q;
    assign oY      = y_q;
    assign oColour = colour_q;
    assign oPlot   = plot_q;
    assign oBusy   = busy_q;
    assign oDone   = done_q;

endmodule
